// File: rtl/mips32_state_dump.sv
// -----------------------------------------------------------------------------
// mips32_state_dump
//
// Post-run state readout engine for pipe_MIPS32. When the core halts (rising
// edge of `halted`) or `start` is pulsed, it walks the register file
// R0..R(NREGS-1) and then an optional window of data memory. Both are read
// through one-cycle-latency read ports. Each word is streamed out on a
// valid/ready interface.
//
// Ports
//   clk1       single clock, rising edge
//   rst_n      asynchronous active-low reset
//   halted     core HALTED flag, rising edge starts a dump
//   start      one-cycle pulse, starts a dump while idle
//   mem_base   first memory word of the window (sampled at trigger)
//   mem_cnt    number of memory words, 0 = none (sampled at trigger)
//   reg_raddr  register-file read address
//   reg_rdata  register data, valid one cycle after reg_raddr
//   mem_raddr  memory read address
//   mem_rdata  memory data, valid one cycle after mem_raddr
//   out_valid  stream word valid
//   out_ready  sink ready
//   out_data   dumped word
//   out_src    0 = register, 1 = memory
//   out_idx    register number or (wrapped) memory address
//   out_last   final word of the dump
//   busy       dump in progress
//   done       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module mips32_state_dump #(
   parameter int NREGS     = 32,
   parameter int DATA_W    = 32,
   parameter int MADDR_W   = 10,
   parameter int MEM_CNT_W = 8
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 halted,
   input  logic                 start,
   input  logic [MADDR_W-1:0]   mem_base,
   input  logic [MEM_CNT_W-1:0] mem_cnt,
   output logic [4:0]           reg_raddr,
   input  logic [DATA_W-1:0]    reg_rdata,
   output logic [MADDR_W-1:0]   mem_raddr,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_src,
   output logic [MADDR_W-1:0]   out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REG_ADDR = 3'd1,
      REG_CAP  = 3'd2,
      REG_OUT  = 3'd3,
      MEM_ADDR = 3'd4,
      MEM_CAP  = 3'd5,
      MEM_OUT  = 3'd6,
      FIN      = 3'd7
   } state_t;

   localparam logic [MEM_CNT_W-1:0] LAST_REG = MEM_CNT_W'(NREGS - 1);

   state_t                 state_r;
   logic                   halted_q_r;
   logic [MADDR_W-1:0]     mem_base_l_r;
   logic [MEM_CNT_W-1:0]   mem_cnt_l_r;
   logic [MEM_CNT_W-1:0]   idx_r;

   logic                   trig_s;
   logic                   hs_s;
   logic                   reg_more_s;
   logic                   mem_more_s;
   logic [MEM_CNT_W-1:0]   idx_nxt_s;
   logic [MADDR_W-1:0]     mem_addr_nxt_s;

   // Trigger, handshake and next-word decode shared by both dump phases.
   always_comb begin
      trig_s         = start | (halted & ~halted_q_r);
      hs_s           = out_valid & out_ready;
      idx_nxt_s      = idx_r + MEM_CNT_W'(1);
      reg_more_s     = (idx_r != LAST_REG);
      // idx+1 == count means the current memory word is the final one.
      mem_more_s     = (idx_nxt_s != mem_cnt_l_r);
      // Address arithmetic wraps modulo 2^MADDR_W by truncation.
      mem_addr_nxt_s = mem_base_l_r + MADDR_W'(idx_nxt_s);
   end

   // Dump sequencer: all outputs registered. Read addresses are loaded on
   // entry to an *_ADDR state so they are presented during that state and the
   // read data can be captured in the following *_CAP state.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         halted_q_r   <= 1'b0;
         mem_base_l_r <= '0;
         mem_cnt_l_r  <= '0;
         idx_r        <= '0;
         reg_raddr    <= 5'd0;
         mem_raddr    <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_src      <= 1'b0;
         out_idx      <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         halted_q_r <= halted;
         done       <= 1'b0;
         case (state_r)
            IDLE: begin
               if (trig_s) begin
                  mem_base_l_r <= mem_base;
                  mem_cnt_l_r  <= mem_cnt;
                  idx_r        <= '0;
                  reg_raddr    <= 5'd0;
                  busy         <= 1'b1;
                  state_r      <= REG_ADDR;
               end else begin
                  state_r      <= IDLE;
               end
            end
            REG_ADDR: begin
               state_r <= REG_CAP;
            end
            REG_CAP: begin
               out_data  <= reg_rdata;
               out_src   <= 1'b0;
               out_idx   <= MADDR_W'(idx_r);
               out_last  <= (idx_r == LAST_REG) && (mem_cnt_l_r == '0);
               out_valid <= 1'b1;
               state_r   <= REG_OUT;
            end
            REG_OUT: begin
               if (hs_s) begin
                  out_valid <= 1'b0;
                  if (reg_more_s) begin
                     idx_r     <= idx_nxt_s;
                     reg_raddr <= idx_nxt_s[4:0];
                     state_r   <= REG_ADDR;
                  end else if (mem_cnt_l_r != '0) begin
                     idx_r     <= '0;
                     mem_raddr <= mem_base_l_r;
                     state_r   <= MEM_ADDR;
                  end else begin
                     state_r   <= FIN;
                  end
               end else begin
                  state_r <= REG_OUT;
               end
            end
            MEM_ADDR: begin
               state_r <= MEM_CAP;
            end
            MEM_CAP: begin
               out_data  <= mem_rdata;
               out_src   <= 1'b1;
               out_idx   <= mem_raddr;
               out_last  <= ~mem_more_s;
               out_valid <= 1'b1;
               state_r   <= MEM_OUT;
            end
            MEM_OUT: begin
               if (hs_s) begin
                  out_valid <= 1'b0;
                  if (mem_more_s) begin
                     idx_r     <= idx_nxt_s;
                     mem_raddr <= mem_addr_nxt_s;
                     state_r   <= MEM_ADDR;
                  end else begin
                     state_r   <= FIN;
                  end
               end else begin
                  state_r <= MEM_OUT;
               end
            end
            FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mips32_state_dump.md
Name: mips32_state_dump

Overview:
- Post-run state readout engine for pipe_MIPS32.
- Once the core halts, it reads the register file, then an optional data-memory window, through one-cycle-latency read ports.
- It streams each word out on a valid/ready interface to the bench or debug host.
- It is the reader counterpart to the program/register preload path, replacing hierarchical peeking of Reg/Mem after a run.

Parameters:
- NREGS, 32, number of registers dumped, R0..R(NREGS-1).
- DATA_W, 32, word width.
- MADDR_W, 10, data-memory address width.
- MEM_CNT_W, 8, width of the memory word-count input.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halted  in  1  core HALTED flag; a rising edge starts a dump.
- start  in  1  one-cycle pulse; starts a dump while idle.
- mem_base  in  MADDR_W  first memory word to dump; sampled at start.
- mem_cnt  in  MEM_CNT_W  number of memory words to dump, 0 = none; sampled at start.
- reg_raddr  out  5  register-file read address.
- reg_rdata  in  DATA_W  register data, valid one cycle after reg_raddr.
- mem_raddr  out  MADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory data, valid one cycle after mem_raddr.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  dumped word.
- out_src  out  1  0 = register, 1 = memory.
- out_idx  out  MADDR_W  register number or memory address.
- out_last  out  1  final word of the dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: out_valid, out_last, busy, done, addresses, out_data, out_src, out_idx.
  - The halted edge detector register is cleared.
- Trigger:
  - trig = start | (halted & ~halted_q), where halted_q is a registered copy of halted.
  - trig is only honoured in IDLE; it is ignored while busy.
  - On trig: latch mem_base and mem_cnt, set idx=0, set busy=1, go to REG_ADDR.
- States: IDLE, REG_ADDR, REG_CAP, REG_OUT, MEM_ADDR, MEM_CAP, MEM_OUT, FIN.
- REG_ADDR: drive reg_raddr=idx; go to REG_CAP next cycle.
- REG_CAP:
  - Register out_data<=reg_rdata, out_src<=0, out_idx<=idx.
  - Set out_last<=(idx==NREGS-1 && mem_cnt_l==0) and out_valid<=1.
  - Go to REG_OUT.
- REG_OUT:
  - Hold all out_* stable while out_valid & ~out_ready.
  - On handshake (out_valid & out_ready): clear out_valid.
    - If idx<NREGS-1: increment idx, go to REG_ADDR.
    - Else if mem_cnt_l!=0: set idx=0, go to MEM_ADDR.
    - Else go to FIN.
- MEM_ADDR / MEM_CAP / MEM_OUT: same as the register phase, with these differences:
  - mem_raddr = mem_base_l + idx, truncated to MADDR_W (address wraps modulo 2^MADDR_W).
  - out_src=1; out_idx = the wrapped address.
  - out_last is set when idx==mem_cnt_l-1.
- FIN: pulse done=1 for one cycle, set busy=0, go to IDLE.
- Throughput: at most one word per 3 cycles. Minimum latency from trig to first out_valid is 3 cycles (trig cycle, ADDR, CAP).
- out_valid never deasserts without a handshake, except on reset.
- halted held high after a dump does not retrigger; only a fresh rising edge or start does.
- halted and start asserted in the same cycle produce a single dump.
- Reset mid-dump aborts immediately. No done pulse; the stream is truncated.
- Register indices above 31 are not supported; NREGS must be ≤32.

Test Plan:
- Run program (R1=10, R2=20, R3=25, R4=R1+R2, R5=R4+R3, HLT) with Reg[k]=k preload, then raise halted with mem_cnt=0 and out_ready=1 -> 32 words out_src=0:
  - idx0..5 carry 0, 10, 20, 25, 30, 55.
  - idx6..31 carry k.
  - out_last only on idx31; done pulses one cycle later; busy spans trig to FIN.
- start with mem_base=10, mem_cnt=3, Mem[10..12]=0xA,0xB,0xC -> after 32 register words, three words with out_src=1, out_idx=10,11,12 and data A,B,C; out_last on idx12.
- Random out_ready backpressure (held low up to 5 cycles) -> out_data/out_idx/out_last stable while stalled; no word lost or duplicated; sequence identical to the no-stall run.
- mem_base=0x3FE, mem_cnt=4 -> out_idx sequence 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
- Assert start while busy, and hold halted high after done -> no second dump; exactly one done pulse.
- Drop rst_n during word idx7 with out_valid=1 -> outputs immediately 0, busy=0, no done; a subsequent start produces a full dump from idx0.
